lfsr_prbs_gen: RTL and testbench

Parametrised linear-feedback shift register and PRBS source, generalising the team's fixed 8-bit LFSR counter.
- Width, tap polynomial and reset seed are parameters.
- Selects Fibonacci or Galois form at load time.
- Supports step-enable, runtime seed load, all-zero seed protection and hardware period measurement.
- Feeds BIST pattern generators and scrambler test paths.

---
 rtl/lfsr_prbs_gen.sv | 81 ++++++++
 tb/tb_lfsr_prbs_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_gen.sv
// rtl/lfsr_prbs_gen.sv - parametrised Fibonacci/Galois LFSR PRBS source with period measurement
module lfsr_prbs_gen #(
  parameter int unsigned          WIDTH    = 8,
  parameter logic [WIDTH-1:0]     TAPS     = 8'b1000_1110,
  parameter logic [WIDTH-1:0]     SEED     = 8'h80,
  parameter logic                 MODE_RST = 1'b0
) (
  input  logic             clk,
  input  logic             NReset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic [WIDTH-1:0] period,
  output logic             period_done,
  output logic             zero_seed
);

  logic             mode_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] cnt;

  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] step_next;
  logic             wrap;

  always_comb begin
    fib_fb    = ^(q & TAPS);
    fib_next  = {fib_fb, q[WIDTH-1:1]};
    gal_next  = {1'b0, q[WIDTH-1:1]} ^ ({WIDTH{q[0]}} & TAPS);
    step_next = mode_q ? gal_next : fib_next;
    wrap      = (step_next == start_q);
  end

  // A zero seed would lock the register, so it is replaced by SEED and flagged.
  always_ff @(posedge clk) begin
    if (!NReset) begin
      q           <= SEED;
      mode_q      <= MODE_RST;
      start_q     <= SEED;
      cnt         <= '0;
      period      <= '0;
      period_done <= 1'b0;
      zero_seed   <= 1'b0;
    end else begin
      period_done <= 1'b0;
      zero_seed   <= 1'b0;
      if (load) begin
        if (seed_in != '0) begin
          q       <= seed_in;
          start_q <= seed_in;
        end else begin
          q         <= SEED;
          start_q   <= SEED;
          zero_seed <= 1'b1;
        end
        mode_q <= mode;
        cnt    <= '0;
      end else if (en) begin
        q <= step_next;
        if (wrap) begin
          period      <= cnt + 1'b1;
          cnt         <= '0;
          period_done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bit_out = q[0];

  a_no_lockup : assert property (@(posedge clk) disable iff (!NReset) q != '0);
  a_done_at_start : assert property (@(posedge clk) disable iff (!NReset) period_done |-> (q == start_q));

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// tb/tb_lfsr_prbs_gen.sv - table, directed and random checks of lfsr_prbs_gen against a reference model
module tb_lfsr_prbs_gen;

  logic       clk;
  logic [3:0] rstn, en, load, mode;
  logic [7:0] seed [4];

  logic [7:0] q_o   [4];
  logic [7:0] per_o [4];
  logic [3:0] bit_o, done_o, zs_o;
  logic [3:0] q1, per1;
  logic [7:0] q0, q2, q3, per0, per2, per3;

  int vectors, miscompares;

  // Four instances: defaults, 4-bit, maximal Fibonacci (0x1D), maximal Galois (0xB8).
  lfsr_prbs_gen u_d0 (
    .clk(clk), .NReset(rstn[0]), .en(en[0]), .load(load[0]), .seed_in(seed[0]), .mode(mode[0]),
    .q(q0), .bit_out(bit_o[0]), .period(per0), .period_done(done_o[0]), .zero_seed(zs_o[0]));

  lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'b1001), .SEED(4'h8), .MODE_RST(1'b0)) u_d1 (
    .clk(clk), .NReset(rstn[1]), .en(en[1]), .load(load[1]), .seed_in(seed[1][3:0]), .mode(mode[1]),
    .q(q1), .bit_out(bit_o[1]), .period(per1), .period_done(done_o[1]), .zero_seed(zs_o[1]));

  lfsr_prbs_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h80), .MODE_RST(1'b0)) u_d2 (
    .clk(clk), .NReset(rstn[2]), .en(en[2]), .load(load[2]), .seed_in(seed[2]), .mode(mode[2]),
    .q(q2), .bit_out(bit_o[2]), .period(per2), .period_done(done_o[2]), .zero_seed(zs_o[2]));

  lfsr_prbs_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h80), .MODE_RST(1'b1)) u_d3 (
    .clk(clk), .NReset(rstn[3]), .en(en[3]), .load(load[3]), .seed_in(seed[3]), .mode(mode[3]),
    .q(q3), .bit_out(bit_o[3]), .period(per3), .period_done(done_o[3]), .zero_seed(zs_o[3]));

  assign q_o[0] = q0;
  assign q_o[1] = {4'b0, q1};
  assign q_o[2] = q2;
  assign q_o[3] = q3;
  assign per_o[0] = per0;
  assign per_o[1] = {4'b0, per1};
  assign per_o[2] = per2;
  assign per_o[3] = per3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state and per-instance parameters.
  int         m_w    [4] = '{8, 4, 8, 8};
  logic [7:0] m_taps [4] = '{8'h8E, 8'h09, 8'h1D, 8'hB8};
  logic [7:0] m_seedp[4] = '{8'h80, 8'h08, 8'h80, 8'h80};
  bit         m_mrst [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] m_q[4], m_start[4], m_cnt[4], m_per[4];
  bit         m_mode[4], m_done[4], m_zs[4];

  function automatic logic [7:0] lfsr_next(int k, logic [7:0] s, bit gal);
    int fb;
    if (gal) return (s >> 1) ^ (s[0] ? m_taps[k] : 8'h00);
    fb = $countones(s & m_taps[k]) % 2;
    return (s >> 1) | (8'(fb) << (m_w[k] - 1));
  endfunction

  function automatic int cycle_len(int k, logic [7:0] start, bit gal);
    logic [7:0] s;
    int n;
    s = start;
    n = 0;
    do begin
      s = lfsr_next(k, s, gal);
      n++;
    end while (s != start && n < 1000);
    return n;
  endfunction

  task automatic model_step(int k);
    logic [7:0] msk, s, nx;
    msk = 8'((1 << m_w[k]) - 1);
    m_done[k] = 1'b0;
    m_zs[k]   = 1'b0;
    if (!rstn[k]) begin
      m_q[k] = m_seedp[k]; m_start[k] = m_seedp[k]; m_mode[k] = m_mrst[k];
      m_cnt[k] = 8'h00; m_per[k] = 8'h00;
    end else if (load[k]) begin
      s = seed[k] & msk;
      if (s == 8'h00) begin
        s = m_seedp[k];
        m_zs[k] = 1'b1;
      end
      m_q[k] = s; m_start[k] = s; m_mode[k] = mode[k]; m_cnt[k] = 8'h00;
    end else if (en[k]) begin
      nx = lfsr_next(k, m_q[k], m_mode[k]);
      m_cnt[k] = (m_cnt[k] + 8'd1) & msk;
      if (nx == m_start[k]) begin
        m_per[k] = m_cnt[k];
        m_cnt[k] = 8'h00;
        m_done[k] = 1'b1;
      end
      m_q[k] = nx;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) model_step(k);
    for (int k = 0; k < 4; k++)
      check($sformatf("model_dut%0d{q,per,bit,done,zs}", k),
            32'({q_o[k], per_o[k], bit_o[k], done_o[k], zs_o[k]}),
            32'({m_q[k], m_per[k], m_q[k][0], m_done[k], m_zs[k]}));
  endtask

  task automatic idle_all();
    rstn = 4'hF; en = 4'h0; load = 4'h0; mode = 4'h0;
    for (int k = 0; k < 4; k++) seed[k] = 8'h00;
  endtask

  typedef struct {
    int         k;
    bit         rn, e, l, md;
    logic [7:0] sd;
    logic [7:0] eq;
    bit         ed, ez;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int k, bit rn, bit e, bit l, bit md, logic [7:0] sd,
                              logic [7:0] eq, bit ed, bit ez);
    vec_t v;
    v.k = k; v.rn = rn; v.e = e; v.l = l; v.md = md; v.sd = sd; v.eq = eq; v.ed = ed; v.ez = ez;
    return v;
  endfunction

  int         pulses, pulse_step;
  logic [7:0] w4_seq [15];

  initial begin
    vectors = 0;
    miscompares = 0;
    idle_all();
    rstn = 4'h0;
    tick();
    tick();
    idle_all();

    // Defaults: reset then two steps; zero-seed load; load with en takes no step.
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h80, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h00, 8'hC0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h00, 8'hE0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 8'h00, 8'h80, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h80, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 8'h5A, 8'h5A, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'h00, 8'h2D, 0, 0));
    // 4-bit Fibonacci x^4+x^3+1 full cycle from 8.
    w4_seq = '{8'hC, 8'hE, 8'hF, 8'h7, 8'hB, 8'h5, 8'hA, 8'hD, 8'h6, 8'h3, 8'h9, 8'h4, 8'h2, 8'h1, 8'h8};
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h08, 0, 0));
    for (int i = 0; i < 15; i++) tbl.push_back(mk(1, 1, 1, 0, 0, 8'h00, w4_seq[i], i == 14, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 8'h08, 0, 0));
    // Galois 0xB8 from seed 01.
    tbl.push_back(mk(3, 1, 0, 1, 1, 8'h01, 8'h01, 0, 0));
    tbl.push_back(mk(3, 1, 1, 0, 0, 8'h00, 8'hB8, 0, 0));
    tbl.push_back(mk(3, 1, 1, 0, 1, 8'h00, 8'h5C, 0, 0));

    foreach (tbl[i]) begin
      idle_all();
      rstn[tbl[i].k] = tbl[i].rn;
      en[tbl[i].k]   = tbl[i].e;
      load[tbl[i].k] = tbl[i].l;
      mode[tbl[i].k] = tbl[i].md;
      seed[tbl[i].k] = tbl[i].sd;
      tick();
      check($sformatf("tbl%0d_q", i), 32'(q_o[tbl[i].k]), 32'(tbl[i].eq));
      check($sformatf("tbl%0d_done", i), 32'(done_o[tbl[i].k]), 32'(tbl[i].ed));
      check($sformatf("tbl%0d_zs", i), 32'(zs_o[tbl[i].k]), 32'(tbl[i].ez));
    end
    idle_all();
    check("w4_period", 32'(per_o[1]), 32'd15);

    // Maximal Fibonacci and Galois runs of 300 steps: one wrap at step 255.
    rstn[2] = 1'b0;
    load[3] = 1'b1; mode[3] = 1'b1; seed[3] = 8'h01;
    tick();
    idle_all();
    en[2] = 1'b1; en[3] = 1'b1;
    pulses = 0;
    pulse_step = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (done_o[2]) begin
        pulses++;
        pulse_step = i;
      end
    end
    check("fib_pulses", 32'(pulses), 32'd1);
    check("fib_pulse_step", 32'(pulse_step), 32'd255);
    check("fib_period", 32'(per_o[2]), 32'd255);
    check("fib_period_vs_cycle", 32'(per_o[2]), 32'(cycle_len(2, 8'h80, 1'b0)));
    check("gal_period", 32'(per_o[3]), 32'd255);
    check("gal_period_vs_cycle", 32'(per_o[3]), 32'(cycle_len(3, 8'h01, 1'b1)));

    // Reset mid-period (cnt = 100) aborts measurement.
    idle_all();
    en[2] = 1'b1;
    repeat (55) tick();
    check("cnt_mid_model", 32'(m_cnt[2]), 32'd100);
    idle_all();
    rstn[2] = 1'b0;
    tick();
    check("rst_mid_q", 32'(q_o[2]), 32'h80);
    check("rst_mid_period", 32'(per_o[2]), 32'd0);
    idle_all();
    en[2] = 1'b1;
    tick();
    check("after_rst_step", 32'(q_o[2]), 32'h40);

    // Random enables, stray mode toggles, loads and resets.
    for (int i = 0; i < 600; i++) begin
      idle_all();
      mode = 4'($urandom);
      en   = 4'($urandom);
      en[2] = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) begin
        load[1] = 1'b1;
        seed[1] = 8'($urandom_range(15));
      end
      if ($urandom_range(49) == 0) rstn[1] = 1'b0;
      if ($urandom_range(31) == 0) begin
        load[3] = 1'b1;
        mode[3] = 1'b1;
        seed[3] = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      end
      tick();
    end
    idle_all();
    check("rand_fib_period", 32'(per_o[2]), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
